// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, grant encoding
// and the round-robin pick rule.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_DM = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_DM = 1'b1
    } grant_t;

    localparam logic [3:0] BYTE_SEL_ALL = 4'hF;

    // Under contention the master that did not win last time goes first.
    function automatic grant_t pick_grant(input logic if_elig, input logic dm_elig,
                                          input grant_t last_grant);
        grant_t g;
        if (if_elig && dm_elig)
            g = (last_grant == GRANT_IF) ? GRANT_DM : GRANT_IF;
        else if (dm_elig)
            g = GRANT_DM;
        else
            g = GRANT_IF;
        return g;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Wait-state counter for a granted transaction; expire is high on the last
// permitted cycle without an ack. TIMEOUT_CYC = 0 disables it.
module mem_bus_arbiter_watchdog #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign expire = (TIMEOUT_CYC != 0) && en && (cnt == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one req/ack memory slave between the instruction-fetch and data ports
// with round-robin grant, pipeline stall request and a hung-slave watchdog.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [3:0]        dm_sel_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_sel_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_req_o,
    output logic              bus_err_o
);

    arb_state_t state;
    grant_t     last_grant;
    grant_t     gnt;
    logic       if_elig;
    logic       dm_elig;
    logic       busy;
    logic       wd_expire;

    // A request still high during its own ack cycle is the old one, not a new one.
    assign if_elig     = if_req_i & ~if_ack_o;
    assign dm_elig     = dm_req_i & ~dm_ack_o;
    assign gnt         = pick_grant(if_elig, dm_elig, last_grant);
    assign stall_req_o = if_elig | dm_elig;
    assign busy        = (state != ARB_IDLE);

    mem_bus_arbiter_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (~busy),
        .en     (busy & ~mem_ack_i),
        .expire (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            last_grant  <= GRANT_IF;
            if_ack_o    <= 1'b0;
            dm_ack_o    <= 1'b0;
            bus_err_o   <= 1'b0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
            mem_ce_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_sel_o   <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            if_ack_o  <= 1'b0;
            dm_ack_o  <= 1'b0;
            bus_err_o <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (if_elig || dm_elig) begin
                        mem_ce_o   <= 1'b1;
                        last_grant <= gnt;
                        if (gnt == GRANT_DM) begin
                            state       <= ARB_BUSY_DM;
                            mem_we_o    <= dm_we_i;
                            mem_sel_o   <= dm_sel_i;
                            mem_addr_o  <= dm_addr_i;
                            mem_wdata_o <= dm_wdata_i;
                        end else begin
                            state       <= ARB_BUSY_IF;
                            mem_we_o    <= 1'b0;
                            mem_sel_o   <= BYTE_SEL_ALL;
                            mem_addr_o  <= if_addr_i;
                            mem_wdata_o <= '0;
                        end
                    end
                end
                ARB_BUSY_IF, ARB_BUSY_DM: begin
                    // A real ack beats the watchdog on the same cycle.
                    if (mem_ack_i || wd_expire) begin
                        state     <= ARB_IDLE;
                        mem_ce_o  <= 1'b0;
                        bus_err_o <= ~mem_ack_i;
                        if (state == ARB_BUSY_IF) begin
                            if_ack_o   <= 1'b1;
                            if_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
                        end else begin
                            dm_ack_o   <= 1'b1;
                            dm_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
                        end
                    end
                end
                default: begin
                    state    <= ARB_IDLE;
                    mem_ce_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: transaction-level reference model plus directed cases
// for latency, round-robin, writes, watchdog and reset abort.
module tb_mem_bus_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [3:0]  dm_sel_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o;
    logic        mem_ce_o;
    logic        mem_we_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        stall_req_o;
    logic        bus_err_o;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_sel_i(dm_sel_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .stall_req_o(stall_req_o), .bus_err_o(bus_err_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the slave and since which cycle.
    int          cyc = 0;
    int          m_owner = 0;   // 0 none, 1 IF, 2 DM
    int          m_start = 0;
    bit          m_last_dm = 1'b0;
    logic        m_ce = 0, m_we = 0, m_if_ack = 0, m_dm_ack = 0, m_err = 0;
    logic [3:0]  m_sel = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_if_rdata = 0, m_dm_rdata = 0;

    task automatic model_step(input logic s_rst, input logic s_if_req, input logic [31:0] s_if_addr,
                              input logic s_dm_req, input logic s_dm_we, input logic [3:0] s_dm_sel,
                              input logic [31:0] s_dm_addr, input logic [31:0] s_dm_wdata,
                              input logic s_mem_ack, input logic [31:0] s_mem_rdata);
        bit prev_if_ack, prev_dm_ack, want_if, want_dm, take_dm, timed_out;
        int elapsed;
        cyc++;
        prev_if_ack = m_if_ack;
        prev_dm_ack = m_dm_ack;
        m_if_ack = 0; m_dm_ack = 0; m_err = 0;
        if (s_rst) begin
            m_owner = 0; m_last_dm = 0; m_ce = 0; m_we = 0; m_sel = 0;
            m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_dm_rdata = 0;
            return;
        end
        if (m_owner == 0) begin
            want_if = s_if_req && !prev_if_ack;
            want_dm = s_dm_req && !prev_dm_ack;
            if (want_if || want_dm) begin
                take_dm = want_dm && (!want_if || !m_last_dm);
                m_last_dm = take_dm;
                m_owner = take_dm ? 2 : 1;
                m_start = cyc;
                m_ce = 1;
                m_we    = take_dm ? s_dm_we : 1'b0;
                m_sel   = take_dm ? s_dm_sel : 4'hF;
                m_addr  = take_dm ? s_dm_addr : s_if_addr;
                m_wdata = take_dm ? s_dm_wdata : 32'h0;
            end
        end else begin
            elapsed = cyc - m_start;      // cycles the slave has seen ce high
            timed_out = (TO != 0) && (elapsed >= TO);
            if (s_mem_ack || timed_out) begin
                if (m_owner == 1) begin
                    m_if_ack = 1; m_if_rdata = s_mem_ack ? s_mem_rdata : 32'h0;
                end else begin
                    m_dm_ack = 1; m_dm_rdata = s_mem_ack ? s_mem_rdata : 32'h0;
                end
                m_err = !s_mem_ack;
                m_ce = 0;
                m_owner = 0;
            end
        end
    endtask

    // Stimulus knobs
    int          slave_wait = 0;
    int          ce_run = 0;
    bit          fix_rd = 0;
    logic [31:0] fixed_rd = 0;
    bit          if_persist = 0, dm_persist = 0, rand_mode = 0, noise_en = 0;

    task automatic new_dm_fields();
        dm_we_i    = 1'($urandom_range(0, 1));
        dm_sel_i   = 4'($urandom);
        dm_addr_i  = $urandom;
        dm_wdata_i = $urandom;
    endtask

    task automatic tick();
        logic s_rst, s_if_req, s_dm_req, s_dm_we, s_mem_ack;
        logic [3:0] s_dm_sel;
        logic [31:0] s_if_addr, s_dm_addr, s_dm_wdata, s_mem_rdata;
        s_rst = rst; s_if_req = if_req_i; s_if_addr = if_addr_i; s_dm_req = dm_req_i;
        s_dm_we = dm_we_i; s_dm_sel = dm_sel_i; s_dm_addr = dm_addr_i; s_dm_wdata = dm_wdata_i;
        s_mem_ack = mem_ack_i; s_mem_rdata = mem_rdata_i;
        @(posedge clk);
        #1;
        model_step(s_rst, s_if_req, s_if_addr, s_dm_req, s_dm_we, s_dm_sel, s_dm_addr,
                   s_dm_wdata, s_mem_ack, s_mem_rdata);
        check("if_ack", if_ack_o, m_if_ack);
        check("dm_ack", dm_ack_o, m_dm_ack);
        check("bus_err", bus_err_o, m_err);
        check("mem_ce", mem_ce_o, m_ce);
        check("if_rdata", if_rdata_o, m_if_rdata);
        check("dm_rdata", dm_rdata_o, m_dm_rdata);
        if (m_ce) begin
            check("mem_we", mem_we_o, m_we);
            check("mem_sel", mem_sel_o, m_sel);
            check("mem_addr", mem_addr_o, m_addr);
            if (m_owner == 2) check("mem_wdata", mem_wdata_o, m_wdata);
        end
        // Masters react to their ack; slave reacts to ce.
        ce_run = mem_ce_o ? ce_run + 1 : 0;
        if (if_ack_o) begin
            if (rand_mode) if_persist = 1'($urandom_range(0, 1));
            if_req_i = if_persist;
            if (if_persist) if_addr_i = $urandom;
        end
        if (dm_ack_o) begin
            if (rand_mode) dm_persist = 1'($urandom_range(0, 1));
            dm_req_i = dm_persist;
            if (dm_persist) new_dm_fields();
        end
        if (rand_mode) begin
            if (!if_req_i && $urandom_range(0, 2) == 0) begin
                if_req_i = 1; if_addr_i = $urandom;
            end
            if (!dm_req_i && $urandom_range(0, 2) == 0) begin
                dm_req_i = 1; new_dm_fields();
            end
        end
        if (mem_ce_o) begin
            if (rand_mode && ce_run == 1)
                slave_wait = ($urandom_range(0, 15) == 0) ? 30 : int'($urandom_range(0, 3));
            mem_ack_i = (ce_run == slave_wait + 1);
        end else begin
            mem_ack_i = noise_en ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        mem_rdata_i = fix_rd ? fixed_rd : $urandom;
        #1;
        check("stall_req", stall_req_o, (if_req_i & ~m_if_ack) | (dm_req_i & ~m_dm_ack));
    endtask

    task automatic drain();
        if_persist = 0; dm_persist = 0;
        for (int i = 0; i < 60; i++) begin
            if (!if_req_i && !dm_req_i && !mem_ce_o) break;
            tick();
        end
        check("drain_bound", {if_req_i, dm_req_i, mem_ce_o}, 3'b000);
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    initial begin
        int cnt;
        bit seen;
        int order[$];
        rst = 1; if_req_i = 0; if_addr_i = 0; dm_req_i = 0; dm_we_i = 0; dm_sel_i = 0;
        dm_addr_i = 0; dm_wdata_i = 0; mem_rdata_i = 0; mem_ack_i = 0;
        tick(); tick();
        rst = 0;
        check("rst_ce", mem_ce_o, 0);
        check("rst_acks", {if_ack_o, dm_ack_o, bus_err_o}, 0);
        check("rst_rdata", if_rdata_o | dm_rdata_o, 0);

        // Single zero-wait fetch
        fix_rd = 1; fixed_rd = 32'h3401_1100; slave_wait = 0;
        if_addr_i = 32'h0000_0004; if_req_i = 1;
        tick();
        check("t1_ce", mem_ce_o, 1);
        check("t1_we", mem_we_o, 0);
        check("t1_sel", mem_sel_o, 4'hF);
        check("t1_addr", mem_addr_o, 32'h4);
        tick();
        check("t1_ack", if_ack_o, 1);
        check("t1_rdata", if_rdata_o, 32'h3401_1100);
        tick();
        check("t1_ack_pulse", if_ack_o, 0);

        // Contention after reset: DM first, then IF
        do_reset();
        fix_rd = 0; slave_wait = 1;
        if_addr_i = 32'h100; dm_addr_i = 32'h200; dm_we_i = 0; dm_sel_i = 4'hF;
        if_req_i = 1; dm_req_i = 1;
        tick();
        check("t2_dm_first", mem_addr_o, 32'h200);
        check("t2_stall", stall_req_o, 1);
        tick(); tick();
        check("t2_dm_ack", dm_ack_o, 1);
        check("t2_stall_if", stall_req_o, 1);
        tick();
        check("t2_if_second", mem_addr_o, 32'h100);
        tick(); tick();
        check("t2_if_ack", if_ack_o, 1);
        check("t2_stall_off", stall_req_o, 0);

        // Continuous contention alternates DM, IF, ...
        do_reset();
        slave_wait = 0; if_persist = 1; dm_persist = 1; if_req_i = 1; dm_req_i = 1;
        for (int i = 0; i < 40 && order.size() < 8; i++) begin
            tick();
            if (dm_ack_o) order.push_back(2);
            if (if_ack_o) order.push_back(1);
        end
        check("t3_count", order.size(), 8);
        for (int i = 0; i < order.size(); i++)
            check("t3_order", order[i], (i % 2 == 0) ? 2 : 1);
        drain();

        // Partial-word write held stable until ack
        slave_wait = 2; dm_we_i = 1; dm_sel_i = 4'b0011; dm_wdata_i = 32'hDEAD_BEEF;
        dm_addr_i = 32'h40; dm_req_i = 1;
        tick();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            check("t4_we", mem_we_o, 1);
            check("t4_sel", mem_sel_o, 4'b0011);
            check("t4_wdata", mem_wdata_o, 32'hDEAD_BEEF);
            tick();
            if (dm_ack_o) begin seen = 1; break; end
        end
        check("t4_ack_seen", seen, 1);
        tick();
        check("t4_ack_pulse", dm_ack_o, 0);
        dm_we_i = 0;

        // Watchdog: slave never acks, then slave acks on the last cycle
        for (int pass = 0; pass < 2; pass++) begin
            slave_wait = (pass == 0) ? 1000 : TO - 1;
            fix_rd = 1; fixed_rd = 32'hDEAD_0001;
            dm_addr_i = 32'h80; dm_req_i = 1;
            tick();
            cnt = 1; seen = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (dm_ack_o) begin seen = 1; break; end
                if (mem_ce_o) cnt++;
            end
            check("t5_ack_seen", seen, 1);
            check("t5_ce_cycles", cnt, TO);
            check("t5_err", bus_err_o, (pass == 0) ? 1 : 0);
            check("t5_rdata", dm_rdata_o, (pass == 0) ? 32'h0 : 32'hDEAD_0001);
            tick();
            check("t5_err_pulse", bus_err_o, 0);
        end
        fix_rd = 0;

        // Reset while fetch is outstanding
        do_reset();
        slave_wait = 1000; if_addr_i = 32'h300; if_req_i = 1;
        tick();
        check("t6_busy", mem_ce_o, 1);
        tick();
        rst = 1;
        tick();
        rst = 0;
        check("t6_ce_drop", mem_ce_o, 0);
        check("t6_no_ack", if_ack_o, 0);
        slave_wait = 0; dm_addr_i = 32'h400; dm_req_i = 1;
        tick();
        check("t6_dm_first", mem_addr_o, 32'h400);
        drain();

        // Randomized traffic with random wait states and idle ack noise
        rand_mode = 1; noise_en = 1;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 0; rand_mode = 0; noise_en = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port memory slave (req/ack, variable wait states) between the OpenMIPS instruction-fetch port and its data-memory port.
- Sits in the SOPC between the core and the unified program/data memory, replacing the direct core-to-rom hookup.
- Round-robin grant under contention; stall request to the core's pipeline control while any master waits.
- Watchdog terminates hung transactions.

Parameters:
- ADDR_W, 32, address width (equals `Inst_Addr).
- DATA_W, 32, data width (equals `Inst_Data).
- TIMEOUT_CYC, 16, maximum cycles a granted transaction may wait for mem_ack_i; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch request, held until if_ack_o
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched instruction, valid with if_ack_o
- if_ack_o  out  1  one-cycle fetch completion pulse
- dm_req_i  in  1  data request, held until dm_ack_o
- dm_we_i  in  1  1 = write
- dm_sel_i  in  4  byte enables
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  write data
- dm_rdata_o  out  DATA_W  read data, valid with dm_ack_o
- dm_ack_o  out  1  one-cycle data completion pulse
- mem_ce_o  out  1  slave request
- mem_we_o  out  1  slave write enable
- mem_sel_o  out  4  slave byte enables
- mem_addr_o  out  ADDR_W  slave address
- mem_wdata_o  out  DATA_W  slave write data
- mem_rdata_i  in  DATA_W  slave read data, valid with mem_ack_i
- mem_ack_i  in  1  slave completion, sampled only while mem_ce_o=1
- stall_req_o  out  1  pipeline stall request
- bus_err_o  out  1  one-cycle pulse on watchdog termination

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst.
- Reset values: all registered outputs 0; state IDLE; wait counter 0; last_grant=IF.
- FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE:
  - A master is eligible when its req=1 and its ack_o=0 this cycle (a req still high during its ack cycle is ignored).
  - Only one eligible master: grant it.
  - Both eligible: grant the one not equal to last_grant, so first contention after reset goes to DM.
  - On grant: register the master's address/we/sel/wdata onto the mem_* outputs; set mem_ce_o=1 next cycle; update last_grant; clear counter.
  - IF grants drive we=0 and sel=4'hF.
- BUSY_x:
  - mem_* outputs held stable.
  - mem_ack_i=1: next cycle the granted ack_o=1, its rdata_o = captured mem_rdata_i (writes also capture), mem_ce_o=0, return to IDLE.
  - No ack: counter increments. If TIMEOUT_CYC≠0 and counter reaches TIMEOUT_CYC-1 with no ack, next cycle ack_o=1 with rdata_o=0, bus_err_o=1, mem_ce_o=0, return to IDLE.
  - An ack arriving on the timeout cycle wins (normal completion, no error).
- Latency: req first sampled at edge N -> mem_ce_o=1 after N. Zero-wait slave acks in the same cycle -> ack_o high cycle N+2.
- Minimum back-to-back spacing: 3 cycles per transaction. The ack cycle is spent in IDLE, which re-arbitrates.
- rdata_o holds its last value between acks, except after a timeout, when it reads 0. ack_o and bus_err_o are single-cycle.
- mem_ack_i in IDLE is ignored.
- stall_req_o is combinational: (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o).
- Reset mid-transaction: abort immediately with no ack pulse; the slave sees mem_ce_o drop the next cycle.
- Masters changing address/data while req=1 are a protocol violation; the captured copy is used.

Decomposition:
- define.v gains: arbiter state encodings (`Arb_Idle, `Arb_BusyIf, `Arb_BusyDm), grant encodings (`Grant_If, `Grant_Dm), and `ByteSel_All 4'hF. Width macros `Inst_Addr/`Inst_Data are reused.
- One natural sub-module: bus_watchdog (counter with clear/enable, parameter TIMEOUT_CYC, expire output).

Test Plan:
- Single fetch, zero-wait slave, if_addr_i=32'h0000_0004, mem_rdata_i=32'h3401_1100 -> mem_ce_o high cycle 1, if_ack_o pulse cycle 2, if_rdata_o=32'h3401_1100, mem_we_o=0, mem_sel_o=4'hF.
- if_req_i and dm_req_i both asserted at cycle 0 after reset, 1-wait slave -> DM served first (mem_addr_o=dm_addr_i), then IF; stall_req_o high until if_ack_o.
- Both masters continuously requesting, 8 transactions -> grants alternate DM,IF,DM,IF...; no master starved.
- Write dm_we_i=1, dm_sel_i=4'b0011, dm_wdata_i=32'hDEAD_BEEF -> mem_we_o=1, mem_sel_o=4'b0011, mem_wdata_o=32'hDEAD_BEEF stable until ack; dm_ack_o one pulse.
- Slave never acks, TIMEOUT_CYC=16 -> mem_ce_o high exactly 16 cycles; then dm_ack_o=1, bus_err_o=1, dm_rdata_o=0 same cycle. Repeat with ack on cycle 16 -> no bus_err_o.
- rst asserted while in BUSY_IF -> next cycle mem_ce_o=0, no if_ack_o, state IDLE; first contention afterwards grants DM.
